// File: rtl/bram_search_pkg.sv
// Shared types and default widths for the BRAM key-search sequencer.
package bram_search_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      DONE
   } state_t;

   localparam int unsigned DATA_WIDTH_DEF    = 8;
   localparam int unsigned ADDRESS_WIDTH_DEF = 8;

endpackage

// File: rtl/bram_search_ctrl.sv
// Clocked scan of a single-port BRAM for a runtime key: two cycles per word
// (issue read, capture data), reporting first match position, count and found.
module bram_search_ctrl
   import bram_search_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
   parameter int unsigned DEPTH         = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [DATA_WIDTH-1:0]    key,
   input  logic                     first_only,
   output logic                     ram_cs,
   output logic                     ram_oe,
   output logic                     ram_we,
   output logic [ADDRESS_WIDTH-1:0] ram_address,
   input  logic [DATA_WIDTH-1:0]    ram_dout,
   output logic                     busy,
   output logic                     done,
   output logic                     found,
   output logic [ADDRESS_WIDTH-1:0] position,
   output logic [ADDRESS_WIDTH:0]   match_count
);

   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
   localparam logic [ADDRESS_WIDTH:0]   CNT_ONE   = (ADDRESS_WIDTH + 1)'(1);

   state_t                   state_q, state_d;
   logic [DATA_WIDTH-1:0]    key_q, key_d;
   logic                     first_only_q, first_only_d;
   logic                     rd_q, rd_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     found_q, found_d;
   logic [ADDRESS_WIDTH-1:0] position_q, position_d;
   logic [ADDRESS_WIDTH:0]   count_q, count_d;
   logic                     hit;
   logic                     last;

   always_comb begin
      hit  = (ram_dout == key_q);
      last = (addr_q == LAST_ADDR) || (hit && first_only_q);
   end

   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      first_only_d = first_only_q;
      rd_d         = rd_q;
      addr_d       = addr_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      found_d      = found_q;
      position_d   = position_q;
      count_d      = count_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = ISSUE;
               key_d        = key;
               first_only_d = first_only;
               found_d      = 1'b0;
               position_d   = '0;
               count_d      = '0;
               busy_d       = 1'b1;
               addr_d       = '0;
               rd_d         = 1'b1;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
            rd_d    = 1'b0;
         end
         CAPTURE: begin
            if (hit) begin
               count_d = count_q + CNT_ONE;
               if (!found_q) begin
                  found_d    = 1'b1;
                  position_d = addr_q;
               end
            end
            // Address is held at the final word so it never passes DEPTH-1.
            if (last) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               rd_d    = 1'b0;
            end else begin
               state_d = ISSUE;
               addr_d  = addr_q + ADDR_ONE;
               rd_d    = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         key_q        <= '0;
         first_only_q <= 1'b0;
         rd_q         <= 1'b0;
         addr_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         found_q      <= 1'b0;
         position_q   <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         first_only_q <= first_only_d;
         rd_q         <= rd_d;
         addr_q       <= addr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         found_q      <= found_d;
         position_q   <= position_d;
         count_q      <= count_d;
      end
   end

   assign ram_cs      = rd_q;
   assign ram_oe      = rd_q;
   assign ram_we      = 1'b0;
   assign ram_address = addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign found       = found_q;
   assign position    = position_q;
   assign match_count = count_q;

endmodule

// File: tb/tb_bram_search_ctrl.sv
// Directed bench for bram_search_ctrl with a registered-read single-port RAM model.
module tb_bram_search_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] key = '0;
   logic       first_only = 1'b0;
   logic       ram_cs, ram_oe, ram_we;
   logic [7:0] ram_address;
   logic [7:0] ram_dout = '0;
   logic       busy, done, found;
   logic [7:0] position;
   logic [8:0] match_count;

   logic [7:0] mem [0:7];
   int tests = 0;
   int fails = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   bram_search_ctrl #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .first_only(first_only),
      .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we), .ram_address(ram_address),
      .ram_dout(ram_dout), .busy(busy), .done(done), .found(found),
      .position(position), .match_count(match_count)
   );

   always @(posedge clk) begin
      if (ram_cs && ram_oe) ram_dout <= mem[ram_address[2:0]];
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_cs"},    32'(ram_cs), 0);
      check({tag, "_oe"},    32'(ram_oe), 0);
      check({tag, "_we"},    32'(ram_we), 0);
      check({tag, "_addr"},  32'(ram_address), 0);
      check({tag, "_busy"},  32'(busy), 0);
      check({tag, "_done"},  32'(done), 0);
      check({tag, "_found"}, 32'(found), 0);
      check({tag, "_pos"},   32'(position), 0);
      check({tag, "_cnt"},   32'(match_count), 0);
   endtask

   task automatic load(input logic [63:0] words);
      for (int i = 0; i < 8; i++) mem[i] = words[63-8*i -: 8];
   endtask

   // Called #1 after an edge with the DUT idle.
   task automatic scan(input string tag, input logic [7:0] k, input logic fo,
                       input int pulse_at, input int rst_at,
                       input int ef, input int ep, input int ec,
                       input int elat, input int emax);
      int n, maxa, d0;
      logic we_seen;
      d0 = done_cnt;
      we_seen = 1'b0;
      start = 1'b1; key = k; first_only = fo;
      @(posedge clk); #1;
      start = 1'b0; key = ~k; first_only = ~fo;
      check({tag, "_busy_on"}, 32'(busy), 1);
      check({tag, "_rd_on"},   32'(ram_cs & ram_oe), 1);
      maxa = int'(ram_address);
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (int'(ram_address) > maxa) maxa = int'(ram_address);
         if (ram_we) we_seen = 1'b1;
         if (n == rst_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_reset_values({tag, "_rst"});
            @(posedge clk); #1;
            check({tag, "_rst_nodone"}, 32'(done_cnt), 32'(d0));
            return;
         end
         start = (n == pulse_at);
         if (done) break;
      end
      start = 1'b0;
      check({tag, "_latency"}, 32'(n), 32'(elat));
      check({tag, "_found"},   32'(found), 32'(ef));
      check({tag, "_pos"},     32'(position), 32'(ep));
      check({tag, "_cnt"},     32'(match_count), 32'(ec));
      check({tag, "_maxaddr"}, 32'(maxa), 32'(emax));
      check({tag, "_we"},      32'(we_seen), 0);
      check({tag, "_busy_off"}, 32'(busy), 0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(done), 0);
      check({tag, "_done_cnt"},   32'(done_cnt), 32'(d0 + 1));
      repeat (2) @(posedge clk); #1;
      check({tag, "_hold_found"}, 32'(found), 32'(ef));
      check({tag, "_hold_cnt"},   32'(match_count), 32'(ec));
   endtask

   initial begin
      load(64'h05_02_07_02_00_09_02_01);
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      check_reset_values("reset");

      scan("all_k2",   8'd2, 1'b0, -1, -1, 1, 1, 3, 16, 7);
      scan("first_k2", 8'd2, 1'b1, -1, -1, 1, 1, 1,  4, 1);
      scan("miss_k3",  8'd3, 1'b0, -1, -1, 0, 0, 0, 16, 7);

      load(64'h00_00_00_00_00_00_00_02);
      scan("last_k2",  8'd2, 1'b1, -1, -1, 1, 7, 1, 16, 7);

      load(64'h05_02_07_02_00_09_02_01);
      scan("ign_start", 8'd2, 1'b0, 3, -1, 1, 1, 3, 16, 7);
      scan("mid_rst",   8'd2, 1'b0, -1, 5, 0, 0, 0, 0, 0);
      scan("after_rst", 8'd2, 1'b0, -1, -1, 1, 1, 3, 16, 7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
